// File: rtl/instruction_fetch_unit_pkg.sv
// Shared FSM encodings and default widths for the fetch unit and the program counter.
package instruction_fetch_unit_pkg;

  localparam int DEFAULT_DATA_SIZE  = 16;
  localparam int DEFAULT_INSTR_SIZE = 16;
  localparam int STATE_W            = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    REQ   = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory read bus and decode handshake of the fetch unit; master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
  parameter int INSTR_SIZE = DEFAULT_INSTR_SIZE
) ();

  logic                  mem_req;
  logic [DATA_SIZE-1:0]  mem_addr;
  logic                  mem_ack;
  logic [INSTR_SIZE-1:0] mem_rdata;
  logic [INSTR_SIZE-1:0] instr;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_timeout.sv
// REQ-phase watchdog for the fetch unit; only compiled when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int              CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so the REQ phase lasts exactly TIMEOUT_CYCLES cycles before expiry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !ack && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && !ack && (count == LAST);

endmodule
`endif

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch stage between program counter and decode.
// Optional REQ timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DATA_SIZE      = DEFAULT_DATA_SIZE,
  parameter int INSTR_SIZE     = DEFAULT_INSTR_SIZE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 fetch_en,
  input  logic [DATA_SIZE-1:0] pc,
  output logic                 pc_inc,
  input  logic                 flush,
  output logic                 fetch_err,
  instruction_fetch_unit_if.master bus
);

  fetch_state_t          state;
  fetch_state_t          state_d;
  logic [DATA_SIZE-1:0]  addr_q;
  logic [INSTR_SIZE-1:0] instr_q;
  logic                  instr_valid_q;
  logic                  discard_q;
  logic                  req_active;

  logic                  load_addr;
  logic                  capture;
  logic                  drop_valid;
  logic                  set_discard;
  logic                  clear_discard;
  logic                  timeout_hit;
  logic                  err_block;

`ifdef FETCH_TIMEOUT_EN
  logic fetch_err_q;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == ISSUE),
    .run     (state == REQ),
    .ack     (bus.mem_ack),
    .expired (timeout_hit)
  );

  // A timeout in the same cycle as a flush still leaves the error set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_err_q <= 1'b0;
    end else if (timeout_hit) begin
      fetch_err_q <= 1'b1;
    end else if (flush) begin
      fetch_err_q <= 1'b0;
    end
  end

  assign fetch_err = fetch_err_q;
  assign err_block = fetch_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign fetch_err          = 1'b0;
  assign err_block          = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d       = state;
    pc_inc        = 1'b0;
    load_addr     = 1'b0;
    capture       = 1'b0;
    drop_valid    = 1'b0;
    set_discard   = 1'b0;
    clear_discard = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en && !err_block) state_d = ISSUE;
      end
      ISSUE: begin
        load_addr = 1'b1;
        state_d   = REQ;
      end
      REQ: begin
        // The memory transaction always completes; a redirect only poisons its data.
        if (bus.mem_ack) begin
          if (discard_q || flush) begin
            clear_discard = 1'b1;
            state_d       = ISSUE;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = HOLD;
          end
        end else if (timeout_hit) begin
          clear_discard = 1'b1;
          state_d       = IDLE;
        end else if (flush) begin
          set_discard = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          drop_valid = 1'b1;
          state_d    = ISSUE;
        end else if (bus.instr_ready) begin
          drop_valid = 1'b1;
          state_d    = fetch_en ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      if (load_addr) addr_q <= pc;
      if (capture) begin
        instr_q       <= bus.mem_rdata;
        instr_valid_q <= 1'b1;
      end else if (drop_valid) begin
        instr_valid_q <= 1'b0;
      end
      if (clear_discard) begin
        discard_q <= 1'b0;
      end else if (set_discard) begin
        discard_q <= 1'b1;
      end
    end
  end

  assign req_active      = (state == REQ);
  assign bus.mem_req     = req_active;
  assign bus.mem_addr    = req_active ? addr_q : '0;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with program-counter and instruction-memory models.
module tb_instruction_fetch_unit;

  localparam int DW = 16;
  localparam int IW = 16;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          fetch_en;
  logic          flush;
  logic [DW-1:0] pc;
  logic          pc_inc;
  logic          fetch_err;

  instruction_fetch_unit_if #(.DATA_SIZE(DW), .INSTR_SIZE(IW)) bus ();

  instruction_fetch_unit #(
    .DATA_SIZE      (DW),
    .INSTR_SIZE     (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fetch_en  (fetch_en),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .flush     (flush),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] exp_q[$];
  int            ack_delay;
  int            req_age;
  logic          tb_discard;
  logic [DW-1:0] load_val;
  logic [DW-1:0] last_req_addr;
  logic [IW-1:0] last_instr;
  int            pc_inc_count;
  int            deliveries;
  int            req_starts;
  int            cyc = 0;
  int            deliver_cyc;
  int            req_cyc_log[$];

  function automatic logic [IW-1:0] mem_word(input logic [DW-1:0] a);
    return a ^ 16'hA5B5;
  endfunction

  // One clock cycle: memory responds, outputs sampled mid-cycle, PC model advances after the edge.
  task automatic cycle();
    logic          exp_inc;
    logic [DW-1:0] next_pc;
    logic [IW-1:0] exp_w;
    if (bus.mem_req) begin
      checks++;
      if (req_age == 0) begin
        req_starts++;
        req_cyc_log.push_back(cyc);
        last_req_addr = bus.mem_addr;
        if (bus.mem_addr !== pc) begin
          errors++;
          $display("[TB] FAIL req_addr: got %h expected %h", bus.mem_addr, pc);
        end
      end else if (bus.mem_addr !== last_req_addr) begin
        errors++;
        $display("[TB] FAIL addr_stable: got %h expected %h", bus.mem_addr, last_req_addr);
      end
      bus.mem_ack   = (req_age == ack_delay);
      bus.mem_rdata = bus.mem_ack ? mem_word(bus.mem_addr) : 16'hDEAD;
      req_age++;
    end else begin
      req_age       = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      checks++;
      if (bus.mem_addr !== {DW{1'b0}}) begin
        errors++;
        $display("[TB] FAIL addr_idle: got %h expected 0000", bus.mem_addr);
      end
    end
    #1;
    exp_inc = bus.mem_req && bus.mem_ack && !flush && !tb_discard;
    checks++;
    if (pc_inc !== exp_inc) begin
      errors++;
      $display("[TB] FAIL pc_inc: got %b expected %b (cycle %0d)", pc_inc, exp_inc, cyc);
    end
    if (exp_inc) exp_q.push_back(mem_word(bus.mem_addr));
    if (pc_inc === 1'b1) pc_inc_count++;
    if (!bus.mem_req) tb_discard = 1'b0;
    else if (bus.mem_ack) tb_discard = 1'b0;
    else if (flush) tb_discard = 1'b1;
    if (bus.instr_valid === 1'b1) begin
      if (flush) begin
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      end else if (bus.instr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_instr: got %h expected none", bus.instr);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.instr !== exp_w) begin
            errors++;
            $display("[TB] FAIL instr: got %h expected %h", bus.instr, exp_w);
          end
        end
        deliveries++;
        deliver_cyc = cyc;
        last_instr  = bus.instr;
      end
    end
    next_pc = flush ? load_val : (exp_inc ? pc + 16'd1 : pc);
    @(posedge clock);
    #1;
    cyc++;
    pc    = next_pc;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    fetch_en        = 1'b0;
    flush           = 1'b0;
    pc              = '0;
    load_val        = '0;
    bus.instr_ready = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    ack_delay       = 1;
    req_age         = 0;
    tb_discard      = 1'b0;
    pc_inc_count    = 0;
    deliveries      = 0;
    req_starts      = 0;
    last_req_addr   = '0;
    last_instr      = '0;
    exp_q.delete();
    req_cyc_log.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_until_req(input int target, input string name);
    int n = 0;
    while (req_starts < target && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (req_starts < target) begin
      errors++;
      $display("[TB] FAIL %s_req_wait: got %0d requests expected %0d", name, req_starts, target);
    end
  endtask

  task automatic run_until_delivered(input int target, input string name);
    int n = 0;
    while (deliveries < target && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (deliveries < target) begin
      errors++;
      $display("[TB] FAIL %s_deliver_wait: got %0d deliveries expected %0d", name, deliveries, target);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    checks += 6;
    if (bus.mem_req !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    if (bus.mem_addr !== 16'h0)   begin errors++; $display("[TB] FAIL rst_mem_addr: got %h expected 0000", bus.mem_addr); end
    if (bus.instr !== 16'h0)      begin errors++; $display("[TB] FAIL rst_instr: got %h expected 0000", bus.instr); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.instr_valid); end
    if (pc_inc !== 1'b0)          begin errors++; $display("[TB] FAIL rst_pc_inc: got %b expected 0", pc_inc); end
    if (fetch_err !== 1'b0)       begin errors++; $display("[TB] FAIL rst_fetch_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_basic_fetch();
    int start;
    $display("[TB] test_basic_fetch");
    do_reset();
    pc = 16'h0010; ack_delay = 1; bus.instr_ready = 1'b1; fetch_en = 1'b1;
    start = cyc;
    run_until_delivered(1, "basic");
    run_until_req(2, "basic");
    checks += 6;
    if (req_cyc_log[0] != start + 2) begin errors++; $display("[TB] FAIL basic_req_latency: got %0d expected %0d", req_cyc_log[0] - start, 2); end
    if (deliver_cyc != start + 4)    begin errors++; $display("[TB] FAIL basic_valid_latency: got %0d expected %0d", deliver_cyc - start, 4); end
    if (req_cyc_log[1] != start + 6) begin errors++; $display("[TB] FAIL basic_refetch_latency: got %0d expected %0d", req_cyc_log[1] - start, 6); end
    if (last_instr !== 16'hA5A5)     begin errors++; $display("[TB] FAIL basic_instr: got %h expected a5a5", last_instr); end
    if (last_req_addr !== 16'h0011)  begin errors++; $display("[TB] FAIL basic_next_addr: got %h expected 0011", last_req_addr); end
    if (pc_inc_count != 1)           begin errors++; $display("[TB] FAIL basic_pc_inc_count: got %0d expected 1", pc_inc_count); end
  endtask

  task automatic test_decode_stall();
    int n = 0;
    int inc_before;
    $display("[TB] test_decode_stall");
    do_reset();
    pc = 16'h0040; ack_delay = 0; bus.instr_ready = 1'b0; fetch_en = 1'b1;
    while (bus.instr_valid !== 1'b1 && n < 20) begin cycle(); n++; end
    inc_before = pc_inc_count;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(16'h0040) || bus.mem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold: got valid=%b instr=%h req=%b expected valid=1 instr=%h req=0",
                 bus.instr_valid, bus.instr, bus.mem_req, mem_word(16'h0040));
      end
    end
    checks += 2;
    if (pc_inc_count != inc_before) begin errors++; $display("[TB] FAIL stall_pc_inc: got %0d expected %0d", pc_inc_count, inc_before); end
    if (req_starts != 1)            begin errors++; $display("[TB] FAIL stall_requests: got %0d expected 1", req_starts); end
    bus.instr_ready = 1'b1;
    run_until_delivered(1, "stall");
  endtask

  task automatic test_flush_pending();
    int n = 0;
    $display("[TB] test_flush_pending");
    do_reset();
    pc = 16'h0100; ack_delay = 3; bus.instr_ready = 1'b1; fetch_en = 1'b1;
    while (bus.mem_req !== 1'b1 && n < 20) begin cycle(); n++; end
    flush = 1'b1; load_val = 16'h0200;
    cycle();
    run_until_req(2, "flush_pend");
    checks += 2;
    if (last_req_addr !== 16'h0200) begin errors++; $display("[TB] FAIL flush_pend_addr: got %h expected 0200", last_req_addr); end
    if (pc_inc_count != 0)          begin errors++; $display("[TB] FAIL flush_pend_pc_inc: got %0d expected 0", pc_inc_count); end
    ack_delay = 1;
    run_until_delivered(1, "flush_pend");
    checks++;
    if (last_instr !== mem_word(16'h0200)) begin errors++; $display("[TB] FAIL flush_pend_instr: got %h expected %h", last_instr, mem_word(16'h0200)); end
  endtask

  task automatic test_flush_races();
    int n = 0;
    $display("[TB] test_flush_races");
    do_reset();
    pc = 16'h0300; ack_delay = 1; bus.instr_ready = 1'b0; fetch_en = 1'b1;
    while (bus.mem_req !== 1'b1 && n < 20) begin cycle(); n++; end
    cycle();
    flush = 1'b1; load_val = 16'h0400;
    cycle();
    run_until_req(2, "flush_ack");
    checks += 2;
    if (last_req_addr !== 16'h0400) begin errors++; $display("[TB] FAIL flush_ack_addr: got %h expected 0400", last_req_addr); end
    if (pc_inc_count != 0)          begin errors++; $display("[TB] FAIL flush_ack_pc_inc: got %0d expected 0", pc_inc_count); end
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin cycle(); n++; end
    flush = 1'b1; load_val = 16'h0500; bus.instr_ready = 1'b1;
    cycle();
    checks += 2;
    if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_hold_valid: got %b expected 0", bus.instr_valid); end
    if (deliveries != 0)          begin errors++; $display("[TB] FAIL flush_hold_delivered: got %0d expected 0", deliveries); end
    run_until_req(3, "flush_hold");
    checks++;
    if (last_req_addr !== 16'h0500) begin errors++; $display("[TB] FAIL flush_hold_addr: got %h expected 0500", last_req_addr); end
    run_until_delivered(1, "flush_hold");
    checks++;
    if (last_instr !== mem_word(16'h0500)) begin errors++; $display("[TB] FAIL flush_hold_instr: got %h expected %h", last_instr, mem_word(16'h0500)); end
  endtask

  task automatic test_wrap_and_reset();
    $display("[TB] test_wrap_and_reset");
    do_reset();
    pc = 16'hFFFF; ack_delay = 1; bus.instr_ready = 1'b1; fetch_en = 1'b1;
    run_until_delivered(1, "wrap");
    ack_delay = 50;
    run_until_req(2, "wrap");
    checks += 3;
    if (last_instr !== mem_word(16'hFFFF)) begin errors++; $display("[TB] FAIL wrap_instr: got %h expected %h", last_instr, mem_word(16'hFFFF)); end
    if (last_req_addr !== 16'h0000)        begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 0000", last_req_addr); end
    if (bus.mem_req !== 1'b1)              begin errors++; $display("[TB] FAIL wrap_req_pending: got %b expected 1", bus.mem_req); end
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (bus.mem_req !== 1'b0)     begin errors++; $display("[TB] FAIL midreq_rst_req: got %b expected 0", bus.mem_req); end
    if (bus.mem_addr !== 16'h0)   begin errors++; $display("[TB] FAIL midreq_rst_addr: got %h expected 0000", bus.mem_addr); end
    if (bus.instr !== 16'h0)      begin errors++; $display("[TB] FAIL midreq_rst_instr: got %h expected 0000", bus.instr); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreq_rst_valid: got %b expected 0", bus.instr_valid); end
    if (pc_inc !== 1'b0)          begin errors++; $display("[TB] FAIL midreq_rst_pc_inc: got %b expected 0", pc_inc); end
  endtask

  task automatic test_timeout();
    int n = 0;
    $display("[TB] test_timeout");
    do_reset();
    pc = 16'h0600; ack_delay = 1000; bus.instr_ready = 1'b1; fetch_en = 1'b1;
    while (bus.mem_req !== 1'b1 && n < 20) begin cycle(); n++; end
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (bus.mem_req === 1'b1 && n < 20) begin cycle(); n++; end
    checks += 3;
    if (n != TO)              begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected %0d", n, TO); end
    if (fetch_err !== 1'b1)   begin errors++; $display("[TB] FAIL timeout_err_set: got %b expected 1", fetch_err); end
    if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_req_drop: got %b expected 0", bus.mem_req); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.mem_req !== 1'b0 || fetch_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_blocked: got req=%b err=%b expected req=0 err=1", bus.mem_req, fetch_err);
      end
    end
    flush = 1'b1; load_val = 16'h0700; ack_delay = 1;
    cycle();
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_clear: got %b expected 0", fetch_err); end
    run_until_delivered(1, "timeout");
    checks += 2;
    if (last_req_addr !== 16'h0700) begin errors++; $display("[TB] FAIL timeout_refetch_addr: got %h expected 0700", last_req_addr); end
    if (pc_inc_count != 1)          begin errors++; $display("[TB] FAIL timeout_pc_inc: got %0d expected 1", pc_inc_count); end
`else
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (bus.mem_req !== 1'b1 || fetch_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_timeout_wait: got req=%b err=%b expected req=1 err=0", bus.mem_req, fetch_err);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_decode_stall();
    test_flush_pending();
    test_flush_races();
    test_wrap_and_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
